lane_pack_arbiter: RTL and testbench

Round-robin arbiter and lane packer for packed multi-dimensional byte vectors. NREQ requesters each offer one WIDTH-bit element. Granted elements fill a packed word organised as [0:LANES-1][0:WIDTH-1], lane 0 first. The block sits in front of consumers of packed-array words and emits full words, or partial words on flush, over a valid/ready handshake.

---
 rtl/lane_pack_arbiter.sv | 138 +++++++++++++
 tb/tb_lane_pack_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_pack_arbiter.sv
// Purpose: round-robin arbiter that packs granted requester elements into lanes of an output word.
// Latency: out_valid rises on the edge that accepts the last lane or samples an effective flush.
// Backpressure: the word is held stable and all grants stay low until out_valid && out_ready.
//
// Ports:
//   clock, resetn         rising-edge clock, synchronous active-low reset
//   req_valid/req_data    per-requester element offer
//   req_ready             one-hot combinational grant (low in HOLD and during reset)
//   flush                 close a partially filled word (ignored when the word is empty or presented)
//   out_valid/out_ready   output word handshake
//   out_data              packed lanes, lane 0 first; unfilled lanes read as zero
//   out_count             number of valid lanes in the presented word
//   out_owner             requester index that supplied each lane; unfilled lanes read as zero
module lane_pack_arbiter #(
  parameter int NREQ  = 4,
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic [0:NREQ-1]                       req_valid,
  input  logic [0:NREQ-1][0:WIDTH-1]            req_data,
  output logic [0:NREQ-1]                       req_ready,
  input  logic                                  flush,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [0:LANES-1][0:WIDTH-1]           out_data,
  output logic [$clog2(LANES+1)-1:0]            out_count,
  output logic [0:LANES-1][0:$clog2(NREQ)-1]    out_owner
);

  localparam int PW = $clog2(NREQ);
  localparam int FW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [FW-1:0]                   fill_idx;
  logic [PW-1:0]                   rr_ptr;
  logic [0:LANES-1][0:WIDTH-1]     lane_q;
  logic [0:LANES-1][0:PW-1]        owner_q;
  logic [CW-1:0]                   count_q;

  logic [PW-1:0]                   gnt_idx;
  logic                            gnt_any;
  logic [PW-1:0]                   cand;
  int                              idx;
  logic                            accept;
  logic                            close_full;
  logic                            close_flush;
  logic [CW-1:0]                   fill_n;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    idx       = 0;
    cand      = '0;
    if (resetn && state == S_FILL) begin
      for (int k = 0; k < NREQ; k++) begin
        idx  = (int'(rr_ptr) + k) % NREQ;
        cand = PW'(idx);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any         = 1'b1;
          gnt_idx         = cand;
          req_ready[cand] = 1'b1;
        end
      end
    end
  end

  assign accept      = gnt_any;
  // Lane count including an accept landing this cycle.
  assign fill_n      = CW'(fill_idx) + CW'(accept);
  assign close_full  = accept && (fill_idx == FW'(LANES - 1));
  // A flush on an empty word does nothing; a flush with the last-lane accept is absorbed by close_full.
  assign close_flush = flush && (fill_n != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: if (close_full || close_flush) state_nxt = S_HOLD;
      S_HOLD: if (out_ready) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_FILL;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      fill_idx <= '0;
      rr_ptr   <= '0;
      lane_q   <= '0;
      owner_q  <= '0;
      count_q  <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            lane_q[fill_idx]  <= req_data[gnt_idx];
            owner_q[fill_idx] <= gnt_idx;
            rr_ptr            <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
          end
          if (close_full)       count_q  <= CW'(LANES);
          else if (close_flush) count_q  <= fill_n;
          else if (accept)      fill_idx <= fill_idx + FW'(1);
        end
        S_HOLD: begin
          // Storage is cleared on the handshake so unfilled lanes of the next word read as zero.
          if (out_ready) begin
            lane_q   <= '0;
            owner_q  <= '0;
            count_q  <= '0;
            fill_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State is a single flop, so this decode is a registered output.
  assign out_valid = (state == S_HOLD);
  assign out_data  = lane_q;
  assign out_owner = owner_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_lane_pack_arbiter.sv
module tb_lane_pack_arbiter;

  localparam int NREQ  = 4;
  localparam int LANES = 4;
  localparam int WIDTH = 8;

  logic                              clock;
  logic                              resetn;
  logic [0:NREQ-1]                   req_valid;
  logic [0:NREQ-1][0:WIDTH-1]        req_data;
  logic [0:NREQ-1]                   req_ready;
  logic                              flush;
  logic                              out_valid;
  logic                              out_ready;
  logic [0:LANES-1][0:WIDTH-1]       out_data;
  logic [2:0]                        out_count;
  logic [0:LANES-1][0:1]             out_owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word under construction is a queue of (data, owner) pairs.
  logic [WIDTH-1:0] m_data[$];
  int               m_own[$];
  int               m_rr    = 0;
  bit               m_hold  = 0;
  bit               m_fresh = 1;  // no element accepted since the last reset

  lane_pack_arbiter #(.NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_owner (out_owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_gnt();
    if (!resetn || m_hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic compare();
    logic [0:NREQ-1]             eg;
    logic [0:LANES-1][0:WIDTH-1] ed;
    logic [0:LANES-1][0:1]       eo;
    int g;
    eg = '0; ed = '0; eo = '0;
    g = exp_gnt();
    if (g >= 0) eg[g] = 1'b1;
    for (int i = 0; i < m_data.size(); i++) begin
      ed[i] = m_data[i];
      eo[i] = 2'(m_own[i]);
    end
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("out_valid", 64'(out_valid), 64'(m_hold));
    if (m_hold || m_data.size() == 0) begin
      chk("out_data",  64'(out_data),  64'(ed));
      chk("out_owner", 64'(out_owner), 64'(eo));
    end
    if (m_hold)       chk("out_count", 64'(out_count), 64'(m_data.size()));
    else if (m_fresh) chk("out_count_rst", 64'(out_count), 64'd0);
  endtask

  task automatic model_update();
    int g;
    g = exp_gnt();
    if (!resetn) begin
      m_data.delete(); m_own.delete();
      m_rr = 0; m_hold = 0; m_fresh = 1;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_data.delete(); m_own.delete();
      end
    end else begin
      if (g >= 0) begin
        m_data.push_back(req_data[g]);
        m_own.push_back(g);
        m_rr = (g + 1) % NREQ;
        m_fresh = 0;
      end
      if (m_data.size() == LANES) m_hold = 1;
      else if (flush && m_data.size() > 0) m_hold = 1;
    end
  endtask

  // Inputs are set at the falling edge before calling step.
  task automatic step();
    #1 compare();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_data = '0; flush = 1'b0; out_ready = 1'b0; resetn = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic all_valid_a0();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i] = 8'hA0 + 8'(i);
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    @(negedge clock);

    // Reset state, with requests pending during reset.
    req_valid = '1;
    step();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    @(negedge clock);

    // Round-robin fairness then backpressure.
    idle_inputs();
    all_valid_a0();
    for (int i = 0; i < NREQ; i++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(4'b1000 >> i));
      step();
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_out_data",  64'(out_data),  64'hA0A1A2A3);
      chk("bp_out_owner", 64'(out_owner), 64'h1B);
      chk("bp_out_count", 64'(out_count), 64'd4);
      step();
    end
    out_ready = 1'b1;
    step();
    #1 chk("rr_resume", 64'(req_ready), 64'b1000);
    step();
    step();

    // Sparse requesters 1 and 3.
    idle_inputs();
    do_reset();
    req_valid = 4'b0101;
    req_data[1] = 8'h11;
    req_data[3] = 8'h33;
    for (int i = 0; i < LANES; i++) step();
    #1;
    chk("sparse_data",  64'(out_data),  64'h11331133);
    chk("sparse_owner", 64'(out_owner), 64'h77);
    out_ready = 1'b1;
    step();

    // Flush of a one-lane word, then flush on an empty word.
    idle_inputs();
    do_reset();
    req_valid = 4'b0010;
    req_data[2] = 8'h5A;
    step();
    req_valid = '0;
    flush = 1'b1;
    step();
    #1;
    chk("flush_valid", 64'(out_valid), 64'd1);
    chk("flush_data",  64'(out_data),  64'h5A000000);
    chk("flush_count", 64'(out_count), 64'd1);
    chk("flush_owner", 64'(out_owner), 64'h80);
    out_ready = 1'b1;
    step();
    step();
    #1 chk("flush_empty", 64'(out_valid), 64'd0);
    flush = 1'b0;
    all_valid_a0();
    #1 chk("rr_after_2", 64'(req_ready), 64'b0001);
    out_ready = 1'b0;

    // Flush coinciding with the last-lane accept.
    idle_inputs();
    do_reset();
    all_valid_a0();
    for (int i = 0; i < LANES - 1; i++) step();
    flush = 1'b1;
    step();
    #1 chk("flush_last_count", 64'(out_count), 64'd4);
    req_valid = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    #1 chk("flush_last_noextra", 64'(out_valid), 64'd0);

    // Reset mid-word.
    idle_inputs();
    do_reset();
    all_valid_a0();
    step();
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(out_count), 64'd0);
    chk("midrst_grant", 64'(req_ready), 64'b1000);
    for (int i = 0; i < LANES; i++) step();
    #1 chk("midrst_word", 64'(out_data), 64'hA0A1A2A3);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) req_data[i] = 8'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      resetn    = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
